// File: rtl/bus_responder_pkg.sv
// Protocol constants shared by the bus responder and the CPU-side requester.
// Message type codes, lane width and the response start symbol.
package bus_responder_pkg;

    localparam int BUS_IO_BITS = 2;

    typedef enum logic [1:0] {
        MSG_NONE       = 2'b00,
        MSG_READ       = 2'b01,
        MSG_WRITE_WORD = 2'b10,
        MSG_WRITE_BYTE = 2'b11
    } msg_e;

    localparam logic [1:0] RX_START_SYM = 2'b01;

    // Byte-write lane select: even address -> low byte, odd -> high byte.
    function automatic logic [1:0] byte_lane(input logic addr_lsb);
        return addr_lsb ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_resp_serializer.sv
// Response side: one-entry read buffer, delay counter and the transmit FSM
// that streams the start symbol and the word back on rx, LSB chunk first.
module bus_resp_serializer
    import bus_responder_pkg::*;
#(
    parameter int IO_BITS    = BUS_IO_BITS,
    parameter int DATA_BITS  = 16,
    parameter int READ_DELAY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cap_i,
    input  logic [DATA_BITS-1:0] cap_data_i,
    output logic [IO_BITS-1:0]   rx_o,
    output logic                 busy_o,
    output logic                 overrun_o
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_WAIT  = 2'd1;
    localparam logic [1:0] TX_START = 2'd2;
    localparam logic [1:0] TX_SEND  = 2'd3;
    localparam int CHUNKS = DATA_BITS / IO_BITS;
    localparam int CNT_W  = 8;

    logic [1:0]           state_q, state_d;
    logic [DATA_BITS-1:0] buf_q, buf_d;
    logic                 valid_q, valid_d;
    logic [3:0]           dly_q, dly_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ovr_q, ovr_d;
    logic                 last_send;

    assign last_send = (state_q == TX_SEND) && (cnt_q == CNT_W'(CHUNKS - 1));

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        valid_d = valid_q;
        dly_d   = dly_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        case (state_q)
            TX_WAIT: begin
                dly_d = dly_q + 4'd1;
                if (int'(dly_q) == READ_DELAY - 1) state_d = TX_START;
            end
            TX_START: begin
                state_d = TX_SEND;
                cnt_d   = '0;
            end
            TX_SEND: begin
                buf_d = buf_q >> IO_BITS;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_send) begin
                    state_d = TX_IDLE;
                    valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        // A capture on the final send cycle reuses the slot the current response just released.
        if (cap_i) begin
            if (!valid_q || last_send) begin
                buf_d   = cap_data_i;
                valid_d = 1'b1;
                dly_d   = '0;
                state_d = (READ_DELAY == 0) ? TX_START : TX_WAIT;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TX_IDLE;
            buf_q   <= '0;
            valid_q <= 1'b0;
            dly_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            valid_q <= valid_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        rx_o = '0;
        if (state_q == TX_START)     rx_o = IO_BITS'(RX_START_SYM);
        else if (state_q == TX_SEND) rx_o = buf_q[IO_BITS-1:0];
    end

    assign busy_o    = valid_q || (state_q != TX_IDLE);
    assign overrun_o = ovr_q;

endmodule

// File: rtl/bus_responder.sv
// Memory-side end of the CPU's serial bus: decodes read / write-word /
// write-byte requests, drives the memory port and hands read data to the serializer.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int IO_BITS    = BUS_IO_BITS,
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 16,
    parameter int READ_DELAY = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IO_BITS-1:0]     tx,
    output logic [IO_BITS-1:0]     rx,
    output logic [ADDR_BITS-1:0]   mem_addr,
    output logic                   mem_re,
    input  logic [DATA_BITS-1:0]   mem_rdata,
    output logic                   mem_we,
    output logic [DATA_BITS-1:0]   mem_wdata,
    output logic [DATA_BITS/8-1:0] mem_be,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_ADDR = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_EXEC = 2'd3;
    localparam int ADDR_CHUNKS = ADDR_BITS / IO_BITS;
    localparam int WORD_CHUNKS = DATA_BITS / IO_BITS;
    localparam int BYTE_CHUNKS = DATA_BITS / 2 / IO_BITS;
    localparam int BE_BITS     = DATA_BITS / 8;
    localparam int CNT_W       = 8;

    logic [1:0]           state_q, state_d;
    msg_e                 msg_q, msg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 re_q;
    logic                 ser_busy;
    logic                 is_exec;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            RX_IDLE: begin
                if (tx != '0) begin
                    msg_d   = msg_e'(tx[1:0]);
                    cnt_d   = '0;
                    state_d = RX_ADDR;
                end
            end
            RX_ADDR: begin
                addr_d = {tx, addr_q[ADDR_BITS-1:IO_BITS]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ADDR_CHUNKS - 1)) begin
                    cnt_d   = '0;
                    state_d = (msg_q == MSG_READ) ? RX_EXEC : RX_DATA;
                end
            end
            RX_DATA: begin
                // A byte payload ends up in the upper half after its shorter shift sequence.
                data_d = {tx, data_q[DATA_BITS-1:IO_BITS]};
                cnt_d  = cnt_q + CNT_W'(1);
                if ((msg_q == MSG_WRITE_WORD && cnt_q == CNT_W'(WORD_CHUNKS - 1)) ||
                    (msg_q == MSG_WRITE_BYTE && cnt_q == CNT_W'(BYTE_CHUNKS - 1)))
                    state_d = RX_EXEC;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RX_IDLE;
            msg_q   <= MSG_NONE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            re_q    <= mem_re;
        end
    end

    assign is_exec   = (state_q == RX_EXEC);
    assign mem_addr  = addr_q;
    assign mem_re    = is_exec && (msg_q == MSG_READ);
    assign mem_we    = is_exec && (msg_q != MSG_READ);
    assign mem_wdata = (msg_q == MSG_WRITE_BYTE) ? {2{data_q[DATA_BITS-1 -: DATA_BITS/2]}} : data_q;

    always_comb begin
        mem_be = '0;
        if (mem_we) mem_be = (msg_q == MSG_WRITE_WORD) ? '1 : BE_BITS'(byte_lane(addr_q[0]));
    end

    bus_resp_serializer #(
        .IO_BITS   (IO_BITS),
        .DATA_BITS (DATA_BITS),
        .READ_DELAY(READ_DELAY)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .cap_i     (re_q),
        .cap_data_i(mem_rdata),
        .rx_o      (rx),
        .busy_o    (ser_busy),
        .overrun_o (overrun)
    );

    assign busy = (state_q != RX_IDLE) || ser_busy;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: directed and random requests checked
// cycle by cycle against a timeline model of responses, strobes, busy and overrun.
module tb_bus_responder;

    localparam int RD = 2;
    localparam logic [1:0] T_READ = 2'b01;
    localparam logic [1:0] T_WORD = 2'b10;
    localparam logic [1:0] T_BYTE = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  tx = '0;
    logic [1:0]  rx;
    logic [15:0] mem_addr;
    logic        mem_re;
    logic [15:0] mem_rdata = '0;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_be;
    logic        busy;
    logic        overrun;

    bus_responder #(
        .IO_BITS(2), .ADDR_BITS(16), .DATA_BITS(16), .READ_DELAY(RD)
    ) dut (
        .clk(clk), .reset(reset), .tx(tx), .rx(rx),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Memory attached to the DUT port; ref_mem is the model's view of its contents.
    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];

    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr[15:1]];
        if (mem_we) begin
            if (mem_be[0]) mem[mem_addr[15:1]][7:0]  <= mem_wdata[7:0];
            if (mem_be[1]) mem[mem_addr[15:1]][15:8] <= mem_wdata[15:8];
        end
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } wr_t;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   in_reset = 1'b1;
    int   last_send = -1;
    int   last_start = 0;
    int   ovr_from = -1;
    logic [1:0]  exp_rx   [int];
    logic [15:0] exp_re   [int];
    wr_t         exp_we   [int];
    bit          exp_busy [int];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_cycle();
        check("rx", 32'(rx), exp_rx.exists(cyc) ? 32'(exp_rx[cyc]) : 32'd0);
        check("mem_re", 32'(mem_re), exp_re.exists(cyc) ? 32'd1 : 32'd0);
        if (exp_re.exists(cyc)) check("re_addr", 32'(mem_addr), 32'(exp_re[cyc]));
        check("mem_we", 32'(mem_we), exp_we.exists(cyc) ? 32'd1 : 32'd0);
        if (exp_we.exists(cyc)) begin
            check("we_addr", 32'(mem_addr), 32'(exp_we[cyc].addr));
            check("we_be", 32'(mem_be), 32'(exp_we[cyc].be));
            check("we_data", 32'(mem_wdata), 32'(exp_we[cyc].wdata));
        end
        check("busy", 32'(busy), exp_busy.exists(cyc) ? 32'd1 : 32'd0);
        check("overrun", 32'(overrun), (ovr_from >= 0 && cyc >= ovr_from) ? 32'd1 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!in_reset) check_cycle();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic mark_busy(input int a, input int b);
        for (int i = a; i <= b; i++) exp_busy[i] = 1'b1;
    endtask

    // Read issued with its memory strobe at cycle e: data lands in the buffer at e+1 unless
    // the previous response still holds it (its final send cycle counts as free).
    task automatic model_read(input int e, input logic [15:0] word);
        int c, s;
        c = e + 1;
        if (c >= last_send) begin
            s = c + 1 + RD;
            exp_rx[s] = 2'b01;
            for (int k = 0; k < 8; k++) exp_rx[s + 1 + k] = word[2*k +: 2];
            mark_busy(c + 1, s + 8);
            last_send  = s + 8;
            last_start = s;
        end else if (ovr_from < 0) begin
            ovr_from = c + 1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tx = '0;
        #1;
        check("rst_rx", 32'(rx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_re", 32'(mem_re), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        exp_rx.delete();
        exp_re.delete();
        exp_we.delete();
        exp_busy.delete();
        last_send = -1;
        ovr_from  = -1;
        in_reset  = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        in_reset = 1'b0;
    endtask

    // Sends one complete message; abort_at = k > 0 pulses reset k cycles after the type cycle.
    task automatic send(input logic [1:0] typ, input logic [15:0] addr,
                        input logic [15:0] data, input int abort_at);
        int t, e, nd;
        logic [1:0] be;
        tick();
        t  = cyc;
        tx = typ;
        nd = (typ == T_READ) ? 0 : (typ == T_WORD) ? 8 : 4;
        e  = t + 9 + nd;
        mark_busy(t + 1, e);
        be = addr[0] ? 2'b10 : 2'b01;
        if (typ == T_READ)      begin exp_re[e] = addr; model_read(e, ref_mem[addr[15:1]]); end
        else if (typ == T_WORD) exp_we[e] = '{addr: addr, be: 2'b11, wdata: data};
        else                    exp_we[e] = '{addr: addr, be: be, wdata: {data[7:0], data[7:0]}};
        for (int i = 0; i < 8 + nd; i++) begin
            tick();
            if (abort_at == i + 1) begin
                do_reset();
                return;
            end
            tx = (i < 8) ? addr[2*i +: 2] : data[2*(i-8) +: 2];
        end
        tick();
        tx = '0;
        if (typ == T_WORD)      ref_mem[addr[15:1]] = data;
        else if (typ == T_BYTE) ref_mem[addr[15:1]][8*addr[0] +: 8] = data[7:0];
    endtask

    initial begin
        logic [1:0]  rtyp;
        logic [15:0] raddr, rdata;
        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h1234 >> 1]     = 16'hBEEF;
        ref_mem[16'h1234 >> 1] = 16'hBEEF;

        // Reset state
        reset = 1'b1;
        idle(3);
        check("reset_rx", 32'(rx), 32'd0);
        check("reset_re", 32'(mem_re), 32'd0);
        check("reset_we", 32'(mem_we), 32'd0);
        check("reset_be", 32'(mem_be), 32'd0);
        check("reset_addr", 32'(mem_addr), 32'd0);
        check("reset_wdata", 32'(mem_wdata), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset    = 1'b0;
        in_reset = 1'b0;
        idle(2);

        // Directed read, word write, odd-address byte write
        send(T_READ, 16'h1234, 16'h0000, 0);
        idle(14);
        send(T_WORD, 16'h0040, 16'hA55A, 0);
        idle(3);
        send(T_BYTE, 16'h0003, 16'h007E, 0);
        idle(3);

        // Read-back; second read captures on the first response's final send cycle,
        // then a write arrives immediately while rx streams
        send(T_READ, 16'h0040, 16'h0000, 0);
        idle(1);
        send(T_READ, 16'h0002, 16'h0000, 0);
        send(T_WORD, 16'h0100, 16'h5AA5, 0);
        idle(14);
        send(T_READ, 16'h0100, 16'h0000, 0);
        idle(14);

        // Random traffic with gaps that never overrun the buffer
        for (int n = 0; n < 40; n++) begin
            rtyp  = 2'($urandom_range(1, 3));
            raddr = 16'($urandom_range(0, 255));
            rdata = 16'($urandom);
            send(rtyp, raddr, rdata, 0);
            idle($urandom_range(1, 4));
        end
        idle(14);

        // Overrun: two reads with no gap, the second is dropped and the flag sticks
        send(T_READ, 16'h0010, 16'h0000, 0);
        send(T_READ, 16'h0012, 16'h0000, 0);
        idle(15);
        send(T_READ, 16'h0014, 16'h0000, 0);
        idle(14);

        // Reset during a write's address phase, then in the middle of a response
        send(T_WORD, 16'h0200, 16'h1111, 5);
        idle(20);
        send(T_READ, 16'h0200, 16'h0000, 0);
        idle(last_start + 4 - cyc);
        do_reset();
        idle(3);
        send(T_READ, 16'h1234, 16'h0000, 0);
        idle(14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
